mem_line_responder: RTL

Backing-memory responder that sits below the `CACHE` block and services its misses and write-throughs. Single-word writes and aligned line-fill reads are accepted over a valid/ready request channel. Each request completes after a fixed access latency. Read data returns as a burst of `LINE_WORDS` beats over a valid/ready response channel with backpressure.

---
 rtl/mem_line_pkg.sv | 32 +++
 rtl/mem_line_array.sv | 27 ++
 rtl/mem_line_responder.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mem_line_pkg.sv
// Shared definitions for the backing-memory line responder:
// FSM state encodings, line-offset width and line-base helper.
package mem_line_pkg;

  localparam int unsigned DEF_LINE_WORDS = 4;
  localparam int unsigned MAX_ADDR_W     = 32;
  localparam int unsigned CNT_W          = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_RESP = 2'd2;
  localparam state_t ST_WACK = 2'd3;

  function automatic int unsigned off_width(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

  localparam int unsigned OFF_W = off_width(DEF_LINE_WORDS);

  // Clears the in-line offset bits so beats always start at the aligned base.
  function automatic logic [MAX_ADDR_W-1:0] line_base(
    input logic [MAX_ADDR_W-1:0] addr,
    input int unsigned           off_w
  );
    logic [MAX_ADDR_W-1:0] mask;
    mask = '1 << off_w;
    return addr & mask;
  endfunction

endpackage

// File: rtl/mem_line_array.sv
// Word storage: synchronous write port, asynchronous read port, no reset
// so contents survive a responder reset.
module mem_line_array #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data_c
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data_c = mem_q[rd_addr];

endmodule

// File: rtl/mem_line_responder.sv
// Backing-memory responder: single-word writes and aligned line-fill reads
// with a fixed access latency and a backpressured response burst.
module mem_line_responder
  import mem_line_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned LATENCY    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last
);

  localparam int unsigned       LOFF_W    = off_width(LINE_WORDS);
  localparam logic [LOFF_W-1:0] LAST_BEAT = LOFF_W'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0]  WAIT_LOAD = CNT_W'(LATENCY - 1);

  state_t              state_q,     state_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic [LOFF_W-1:0]   beat_q,      beat_d;
  logic                we_q,        we_d;
  logic [ADDR_W-1:0]   addr_q,      addr_d;
  logic [DATA_W-1:0]   wdata_q,     wdata_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q,  rsp_data_d;
  logic                rsp_last_q,  rsp_last_d;

  logic                mem_we_c;
  logic [LOFF_W-1:0]   rd_beat_c;
  logic [ADDR_W-1:0]   rd_addr_c;
  logic [DATA_W-1:0]   rd_data_c;

  // Beat to be presented next: 0 when entering RESP, beat+1 while streaming.
  assign rd_beat_c = (state_q == ST_RESP) ? beat_q + LOFF_W'(1) : '0;
  assign rd_addr_c = ADDR_W'(line_base(MAX_ADDR_W'(addr_q), LOFF_W)) | ADDR_W'(rd_beat_c);

  mem_line_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk       (clk),
    .wr_en     (mem_we_c),
    .wr_addr   (req_addr),
    .wr_data   (req_wdata),
    .rd_addr   (rd_addr_c),
    .rd_data_c (rd_data_c)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    beat_d      = beat_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_last_d  = rsp_last_q;
    mem_we_c    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d        = req_we;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          cnt_d       = WAIT_LOAD;
          req_ready_d = 1'b0;
          mem_we_c    = req_we;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          rsp_valid_d = 1'b1;
          if (we_q) begin
            rsp_data_d = wdata_q;
            rsp_last_d = 1'b1;
            state_d    = ST_WACK;
          end else begin
            beat_d     = '0;
            rsp_data_d = rd_data_c;
            rsp_last_d = 1'b0;
            state_d    = ST_RESP;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          if (beat_q == LAST_BEAT) begin
            beat_d      = '0;
            rsp_valid_d = 1'b0;
            rsp_last_d  = 1'b0;
            req_ready_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            beat_d     = rd_beat_c;
            rsp_data_d = rd_data_c;
            rsp_last_d = (rd_beat_c == LAST_BEAT);
          end
        end
      end
      ST_WACK: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_last_d  = 1'b0;
          req_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        rsp_last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      beat_q      <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      beat_q      <= beat_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_last  = rsp_last_q;

endmodule
